instruction_fetch: RTL and testbench

- Fetch stage of the Experimento1 mini-processor.
- Owns the program counter and drives the combinational instruction ROM address.
- Registers the returned 28-bit instruction into an instruction register for the decode/execute stage.
- Resolves unconditional jumps locally, executes NOP-with-count delays, and accepts branch redirects and stalls from execute.

---
 rtl/instruction_fetch.sv | 133 +++++++++++++
 tb/tb_instruction_fetch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch -- fetch stage of the Experimento1 mini-processor.
//
// Holds the program counter, addresses the combinational instruction ROM, and
// registers the returned instruction for decode. Unconditional jumps are
// resolved here without a bubble. A NOP carrying a non-zero count N is issued
// and then followed by exactly N bubble slots. Execute can redirect fetch with
// a taken branch, or freeze it with a stall.
//
// Ports:
//   Clock          in   1   rising-edge clock
//   Reset          in   1   synchronous, active-low reset
//   oIROMAddress   out  16  current PC, drives the ROM address
//   iInstruction   in   28  ROM data at oIROMAddress (same cycle)
//   iStall         in   1   execute not ready; all fetch state holds
//   iBranchTaken   in   1   execute resolved a taken branch
//   iBranchTarget  in   16  branch destination
//   oInstruction   out  28  registered instruction issued to decode
//   oPC            out  16  address oInstruction was fetched from
//   oValid         out  1   oInstruction is a real instruction (0 = bubble)
module instruction_fetch #(
  parameter logic [15:0] RESET_PC    = 16'd0,
  parameter logic [3:0]  NOP_OPCODE  = 4'h0,
  parameter logic [3:0]  JMP_OPCODE  = 4'h1,
  parameter int unsigned DELAY_WIDTH = 24
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oIROMAddress,
  input  logic [27:0] iInstruction,
  input  logic        iStall,
  input  logic        iBranchTaken,
  input  logic [15:0] iBranchTarget,
  output logic [27:0] oInstruction,
  output logic [15:0] oPC,
  output logic        oValid
);

  typedef enum logic {
    FETCH = 1'b0,
    DELAY = 1'b1
  } state_e;

  // Word driven to decode whenever the slot is a bubble.
  localparam logic [27:0] BUBBLE_WORD = {NOP_OPCODE, 24'd0};

  state_e                 state_q, state_d;
  logic [15:0]            pc_q, pc_d;
  logic [27:0]            instr_q, instr_d;
  logic [15:0]            issued_pc_q, issued_pc_d;
  logic                   valid_q, valid_d;
  logic [DELAY_WIDTH-1:0] count_q, count_d;

  logic [3:0]  opcode;
  logic [23:0] payload;
  logic [15:0] jmp_target;

  assign opcode     = iInstruction[27:24];
  assign payload    = iInstruction[23:0];
  assign jmp_target = {8'h00, iInstruction[23:16]};

  // The ROM is combinational, so the PC register addresses it directly.
  assign oIROMAddress = pc_q;
  assign oInstruction = instr_q;
  assign oPC          = issued_pc_q;
  assign oValid       = valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    issued_pc_d = issued_pc_q;
    valid_d     = valid_q;
    count_d     = count_q;

    if (iBranchTaken) begin
      // Flush the single wrong-path slot; the target issues two edges later.
      pc_d    = iBranchTarget;
      valid_d = 1'b0;
      instr_d = BUBBLE_WORD;
      count_d = '0;
      state_d = FETCH;
    end else if (!iStall) begin
      unique case (state_q)
        FETCH: begin
          instr_d     = iInstruction;
          issued_pc_d = pc_q;
          valid_d     = 1'b1;
          if (opcode == JMP_OPCODE) begin
            pc_d = jmp_target;
          end else begin
            pc_d = pc_q + 16'd1;
            if (opcode == NOP_OPCODE && payload != 24'd0) begin
              count_d = DELAY_WIDTH'(payload);
              state_d = DELAY;
            end
          end
        end
        DELAY: begin
          valid_d = 1'b0;
          instr_d = BUBBLE_WORD;
          // Leaving on a count of 1 yields exactly N bubbles; a zero count is
          // unreachable but also exits so the counter can never wrap.
          if (count_q <= DELAY_WIDTH'(1)) begin
            count_d = '0;
            state_d = FETCH;
          end else begin
            count_d = count_q - DELAY_WIDTH'(1);
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= BUBBLE_WORD;
      issued_pc_q <= 16'd0;
      valid_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      issued_pc_q <= issued_pc_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch -- self-checking bench for instruction_fetch.
//
// The ROM is an array inside the bench. A behavioural model tracks the
// program counter, the issued slot and the number of bubbles still owed after
// a NOP, and is advanced once per rising edge alongside the DUT.
module tb_instruction_fetch;

  localparam logic [15:0] RESET_PC = 16'd0;
  localparam logic [3:0]  NOP_OP   = 4'h0;
  localparam logic [3:0]  JMP_OP   = 4'h1;
  localparam logic [3:0]  ADD_OP   = 4'h2;
  localparam logic [3:0]  SUB_OP   = 4'h3;
  localparam logic [27:0] BUBBLE   = {NOP_OP, 24'd0};

  logic        Clock = 1'b0;
  logic        clk_run = 1'b1;
  logic        Reset = 1'b0;
  logic [15:0] oIROMAddress;
  logic [27:0] iInstruction;
  logic        iStall = 1'b0;
  logic        iBranchTaken = 1'b0;
  logic [15:0] iBranchTarget = 16'd0;
  logic [27:0] oInstruction;
  logic [15:0] oPC;
  logic        oValid;

  logic [27:0] rom [0:65535];
  assign iInstruction = rom[oIROMAddress];

  int total = 0;
  int bad = 0;

  // Behavioural reference state.
  logic [15:0] m_pc = RESET_PC;
  logic [27:0] m_instr = BUBBLE;
  logic [15:0] m_opc = 16'd0;
  logic        m_valid = 1'b0;
  int          m_owed = 0;

  always #5 if (clk_run) Clock = ~Clock;

  instruction_fetch #(
    .RESET_PC(RESET_PC), .NOP_OPCODE(NOP_OP), .JMP_OPCODE(JMP_OP), .DELAY_WIDTH(24)
  ) dut (
    .Clock(Clock), .Reset(Reset), .oIROMAddress(oIROMAddress),
    .iInstruction(iInstruction), .iStall(iStall), .iBranchTaken(iBranchTaken),
    .iBranchTarget(iBranchTarget), .oInstruction(oInstruction), .oPC(oPC),
    .oValid(oValid)
  );

  // One rising edge: evaluate the model on the pre-edge inputs, then land
  // 1 time unit after the edge with model and DUT both updated.
  task automatic tick();
    logic [15:0] n_pc;
    logic [27:0] n_instr;
    logic [15:0] n_opc;
    logic        n_valid;
    int          n_owed;
    logic [27:0] word;
    n_pc = m_pc; n_instr = m_instr; n_opc = m_opc; n_valid = m_valid; n_owed = m_owed;
    if (!Reset) begin
      n_pc = RESET_PC; n_instr = BUBBLE; n_opc = 16'd0; n_valid = 1'b0; n_owed = 0;
    end else if (iBranchTaken) begin
      n_pc = iBranchTarget; n_instr = BUBBLE; n_valid = 1'b0; n_owed = 0;
    end else if (iStall) begin
      // nothing moves
    end else if (m_owed > 0) begin
      n_instr = BUBBLE; n_valid = 1'b0; n_owed = m_owed - 1;
    end else begin
      word = rom[m_pc];
      n_instr = word; n_opc = m_pc; n_valid = 1'b1;
      if (word[27:24] == JMP_OP) begin
        n_pc = {8'h00, word[23:16]};
      end else begin
        n_pc = m_pc + 16'd1;
        if (word[27:24] == NOP_OP) n_owed = int'(word[23:0]);
      end
    end
    @(posedge Clock);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_opc = n_opc; m_valid = n_valid; m_owed = n_owed;
  endtask

  task automatic branch_to(input logic [15:0] tgt);
    iBranchTaken = 1'b1; iBranchTarget = tgt;
    tick();
    iBranchTaken = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick(); tick();
    total++; if (oValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", oValid); end
    total++; if (oPC !== 16'd0) begin bad++; $display("FAIL reset_opc: got %h want 0000", oPC); end
    total++; if (oInstruction !== BUBBLE) begin bad++; $display("FAIL reset_instr: got %h want %h", oInstruction, BUBBLE); end
    total++; if (oIROMAddress !== RESET_PC) begin bad++; $display("FAIL reset_pc: got %h want %h", oIROMAddress, RESET_PC); end
    Reset = 1'b1;
    $display("reset: valid=%b pc=%h", oValid, oIROMAddress);
  endtask

  task automatic test_straight_line();
    rom[0] = {ADD_OP, 24'h000102}; rom[1] = {SUB_OP, 24'h000304}; rom[2] = {ADD_OP, 24'h000506};
    Reset = 1'b0; tick(); Reset = 1'b1;
    total++; if (oValid !== 1'b0) begin bad++; $display("FAIL straight_first_slot: got valid %b want 0", oValid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (oValid !== 1'b1 || oPC !== 16'(i) || oInstruction !== rom[i]) begin
        bad++; $display("FAIL straight_issue%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, oValid, oPC, oInstruction, 16'(i), rom[i]);
      end
      $display("straight: pc=%h ins=%h valid=%b", oPC, oInstruction, oValid);
    end
  endtask

  task automatic test_nop_delay();
    rom[0] = {NOP_OP, 24'd3}; rom[1] = {ADD_OP, 24'h00AAAA};
    Reset = 1'b0; tick(); Reset = 1'b1;
    tick();
    total++; if (oValid !== 1'b1 || oPC !== 16'd0 || oInstruction !== rom[0]) begin
      bad++; $display("FAIL nop_issue: got v=%b pc=%h ins=%h", oValid, oPC, oInstruction); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (oValid !== 1'b0 || oIROMAddress !== 16'd1 || oInstruction !== BUBBLE) begin
        bad++; $display("FAIL nop_bubble%0d: got v=%b addr=%h ins=%h want v=0 addr=0001", i, oValid, oIROMAddress, oInstruction); end
    end
    tick();
    total++; if (oValid !== 1'b1 || oPC !== 16'd1 || oInstruction !== rom[1]) begin
      bad++; $display("FAIL nop_after: got v=%b pc=%h ins=%h want v=1 pc=0001 ins=%h", oValid, oPC, oInstruction, rom[1]); end
    $display("nop_delay: next pc=%h valid=%b", oPC, oValid);
  endtask

  task automatic test_jmp();
    rom[4] = {JMP_OP, 8'd2, 16'h0000}; rom[2] = {SUB_OP, 24'h001234};
    branch_to(16'd4);
    tick();
    total++; if (oValid !== 1'b1 || oPC !== 16'd4 || oInstruction !== rom[4]) begin
      bad++; $display("FAIL jmp_issue: got v=%b pc=%h ins=%h", oValid, oPC, oInstruction); end
    tick();
    total++; if (oValid !== 1'b1 || oPC !== 16'd2 || oInstruction !== rom[2]) begin
      bad++; $display("FAIL jmp_target: got v=%b pc=%h want v=1 pc=0002", oValid, oPC); end
    $display("jmp: landed pc=%h valid=%b", oPC, oValid);
  endtask

  task automatic test_branch_over_stall();
    rom[8] = {ADD_OP, 24'h008888};
    branch_to(16'd5);
    iStall = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 16'h0008;
    tick();
    iStall = 1'b0; iBranchTaken = 1'b0;
    total++; if (oValid !== 1'b0 || oIROMAddress !== 16'h0008) begin
      bad++; $display("FAIL branch_flush: got v=%b pc=%h want v=0 pc=0008", oValid, oIROMAddress); end
    tick();
    total++; if (oValid !== 1'b1 || oPC !== 16'h0008 || oInstruction !== rom[8]) begin
      bad++; $display("FAIL branch_target: got v=%b pc=%h ins=%h", oValid, oPC, oInstruction); end
    $display("branch: pc=%h valid=%b", oPC, oValid);
  endtask

  task automatic test_stall_and_delay();
    int bubbles = 0;
    int stalls = 0;
    bit issued = 0;
    bit stall_now;
    rom[16'h10] = {ADD_OP, 24'h000010}; rom[16'h11] = {SUB_OP, 24'h000011};
    rom[16'h12] = {NOP_OP, 24'd5};      rom[16'h13] = {ADD_OP, 24'h000013};
    branch_to(16'h0010);
    tick();
    iStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (oValid !== 1'b1 || oPC !== 16'h0010 || oInstruction !== rom[16'h10] || oIROMAddress !== 16'h0011) begin
        bad++; $display("FAIL stall_hold%0d: got v=%b pc=%h addr=%h want v=1 pc=0010 addr=0011", i, oValid, oPC, oIROMAddress); end
    end
    iStall = 1'b0;
    tick(); tick();
    total++; if (oPC !== 16'h0012 || oInstruction !== rom[16'h12]) begin
      bad++; $display("FAIL stall_nop_issue: got pc=%h ins=%h want pc=0012", oPC, oInstruction); end
    for (int c = 0; c < 40 && !issued; c++) begin
      stall_now = (bubbles == 2 && stalls < 4);
      iStall = stall_now;
      tick();
      if (stall_now) begin
        stalls++;
        total++; if (oValid !== 1'b0 || oIROMAddress !== 16'h0013) begin
          bad++; $display("FAIL delay_stall_hold: got v=%b addr=%h want v=0 addr=0013", oValid, oIROMAddress); end
      end else if (oValid) issued = 1;
      else bubbles++;
    end
    iStall = 1'b0;
    total++; if (!issued || bubbles != 5 || oPC !== 16'h0013) begin
      bad++; $display("FAIL delay_with_stall: got bubbles=%0d pc=%h want bubbles=5 pc=0013", bubbles, oPC); end
    $display("stall_delay: bubbles=%0d stalls=%0d", bubbles, stalls);
  endtask

  task automatic test_pc_wrap();
    rom[16'hFFFF] = {ADD_OP, 24'h00FFFF};
    branch_to(16'hFFFF);
    tick();
    total++; if (oPC !== 16'hFFFF || oValid !== 1'b1 || oIROMAddress !== 16'h0000) begin
      bad++; $display("FAIL pc_wrap: got opc=%h addr=%h want opc=ffff addr=0000", oPC, oIROMAddress); end
    $display("wrap: addr=%h", oIROMAddress);
  endtask

  task automatic test_reset_mid_delay();
    rom[16'h20] = {NOP_OP, 24'd4000}; rom[0] = {SUB_OP, 24'h000777};
    branch_to(16'h0020);
    tick();
    repeat (100) tick();
    total++; if (oValid !== 1'b0 || oIROMAddress !== 16'h0021) begin
      bad++; $display("FAIL long_delay: got v=%b addr=%h want v=0 addr=0021", oValid, oIROMAddress); end
    Reset = 1'b0; tick(); Reset = 1'b1;
    total++; if (oIROMAddress !== RESET_PC || oValid !== 1'b0 || oPC !== 16'd0 || oInstruction !== BUBBLE) begin
      bad++; $display("FAIL reset_abort: got addr=%h v=%b pc=%h ins=%h", oIROMAddress, oValid, oPC, oInstruction); end
    tick();
    total++; if (oValid !== 1'b1 || oPC !== RESET_PC || oInstruction !== rom[0]) begin
      bad++; $display("FAIL reset_refetch: got v=%b pc=%h ins=%h want v=1 ins=%h", oValid, oPC, oInstruction, rom[0]); end
    $display("reset_mid_delay: pc=%h valid=%b", oPC, oValid);
  endtask

  task automatic test_reset_clock_stopped();
    @(negedge Clock); #1;
    clk_run = 1'b0;
    Reset = 1'b0;
    #50;
    total++; if (oValid !== m_valid || oPC !== m_opc || oIROMAddress !== m_pc || m_valid !== 1'b1) begin
      bad++; $display("FAIL async_reset: got v=%b pc=%h addr=%h want v=%b pc=%h addr=%h", oValid, oPC, oIROMAddress, m_valid, m_opc, m_pc); end
    clk_run = 1'b1;
    tick();
    Reset = 1'b1;
    total++; if (oValid !== 1'b0 || oIROMAddress !== RESET_PC) begin
      bad++; $display("FAIL reset_on_edge: got v=%b addr=%h", oValid, oIROMAddress); end
    $display("reset_clock_stopped: valid=%b addr=%h", oValid, oIROMAddress);
  endtask

  task automatic test_random();
    int r;
    int errs = 0;
    for (int a = 0; a < 256; a++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      rom[a] = {NOP_OP, 24'($urandom_range(0, 4))};
      else if (r < 4) rom[a] = {JMP_OP, 8'($urandom_range(0, 255)), 16'($urandom)};
      else if (r < 7) rom[a] = {ADD_OP, 24'($urandom)};
      else            rom[a] = {SUB_OP, 24'($urandom)};
    end
    Reset = 1'b0; tick(); Reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      iStall        = ($urandom_range(0, 4) == 0);
      iBranchTaken  = ($urandom_range(0, 19) == 0);
      iBranchTarget = 16'($urandom_range(0, 255));
      Reset         = ($urandom_range(0, 99) != 0);
      tick();
      total++;
      if (oValid !== m_valid || oPC !== m_opc || oInstruction !== m_instr || oIROMAddress !== m_pc) begin
        bad++; errs++;
        if (errs <= 10)
          $display("FAIL random_c%0d: got v=%b pc=%h ins=%h addr=%h want v=%b pc=%h ins=%h addr=%h",
                   c, oValid, oPC, oInstruction, oIROMAddress, m_valid, m_opc, m_instr, m_pc);
      end
    end
    Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0;
    $display("random: 3000 cycles, mismatching=%0d", errs);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) rom[a] = {ADD_OP, 8'h00, 16'(a)};
    test_reset();
    test_straight_line();
    test_nop_delay();
    test_jmp();
    test_branch_over_stall();
    test_stall_and_delay();
    test_pc_wrap();
    test_reset_mid_delay();
    test_reset_clock_stopped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
